ram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the team's single-port synchronous RAM (1024 x 8, registered read).
- Serialises A/B read and write requests onto one RAM port and produces the RAM strobes: ram_cs, ram_rd, ram_wr.
- Returns read data and a completion pulse to the served requester.
- RAM data is carried on separate wdata/rdata buses; no inout inside this block.

---
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter/sequencer for a single-port registered-read RAM
// Define ARB_FIXED_PRIO_EN to make A win every tie (B may starve); default build is round-robin.
module ram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          ram_cs,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_sel_b;
    logic          r_we;
    logic          r_a_gnt;
    logic          r_b_gnt;
    logic          r_a_ack;
    logic          r_b_ack;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          r_ram_cs;
    logic          r_ram_rd;
    logic          r_ram_wr;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          w_start;
    logic          w_pick_b;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_start = a_req | b_req;
    assign w_we    = w_pick_b ? b_we    : a_we;
    assign w_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_wdata = w_pick_b ? b_wdata : a_wdata;

`ifdef ARB_FIXED_PRIO_EN
    assign w_pick_b = ~a_req;
`else
    // r_last_b resets to 1 so that A wins the first tie
    logic r_last_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (r_state == IDLE && w_start) begin
            r_last_b <= w_pick_b;
        end
    end

    assign w_pick_b = b_req & (~a_req | ~r_last_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = ACCESS;
            ACCESS:  w_next_state = r_we ? IDLE : CAPTURE;
            CAPTURE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes are armed at the grant edge so that they are high exactly during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_b     <= 1'b0;
            r_we        <= 1'b0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_ram_cs <= 1'b0;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sel_b     <= w_pick_b;
                        r_we        <= w_we;
                        r_ram_addr  <= w_addr;
                        r_ram_wdata <= w_wdata;
                        r_a_gnt     <= ~w_pick_b;
                        r_b_gnt     <= w_pick_b;
                        r_ram_cs    <= 1'b1;
                        r_ram_wr    <= w_we;
                        r_ram_rd    <= ~w_we;
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_a_ack <= ~r_sel_b;
                        r_b_ack <= r_sel_b;
                    end
                end
                CAPTURE: begin
                    r_a_ack <= ~r_sel_b;
                    r_b_ack <= r_sel_b;
                    if (r_sel_b) begin
                        r_b_rdata <= ram_rdata;
                    end else begin
                        r_a_rdata <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign ram_cs    = r_ram_cs;
    assign ram_rd    = r_ram_rd;
    assign ram_wr    = r_ram_wr;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule
